// File: rtl/apb_master.sv
// apb_master -- single-outstanding APB3 master with a simple valid/ready command
// port and a one-cycle response pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the number of
// consecutive PREADY-low ACCESS cycles to TIMEOUT_CYCLES. Once that limit is
// hit, the transfer ends with rsp_err=1 and rsp_rdata=0.
// Every output is registered except cmd_ready, which is decoded from the state.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // local command / response port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB3 master side
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;

    logic                    accept_s;
    logic                    timeout_s;
    logic                    complete_s;

    logic                    psel_s;
    logic                    penable_s;
    logic                    pwrite_s;
    logic [ADDR_WIDTH-1:0]   paddr_s;
    logic [DATA_WIDTH-1:0]   pwdata_s;
    logic                    rsp_valid_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_s;
    logic                    rsp_err_s;

    assign cmd_ready  = (state_r == IDLE);
    assign accept_s   = cmd_valid && (state_r == IDLE);
    // A real slave completion takes priority over a coincident timeout.
    assign complete_s = PSELx && PENABLE && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TCNT_W-1:0] tcnt_r;

    // The timeout fires in the ACCESS cycle that would be the TIMEOUT_CYCLES-th wait.
    assign timeout_s = (state_r == ACCESS) && !PREADY &&
                       (tcnt_r == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive PREADY-low ACCESS cycles; clear whenever ACCESS is left.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tcnt_r <= '0;
        end else if ((state_r == ACCESS) && !PREADY && !timeout_s) begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
        end else begin
            tcnt_r <= '0;
        end
    end
`else
    // Without the timeout feature ACCESS waits for PREADY indefinitely; the
    // parameter stays on the interface so both builds share one instantiation.
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
    assign timeout_s            = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: IDLE -> SETUP on accept, SETUP -> ACCESS always,
    // ACCESS -> IDLE on completion or timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                if (complete_s || timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; address/data/direction hold when idle.
    always_comb begin
        psel_s      = PSELx;
        penable_s   = PENABLE;
        pwrite_s    = PWRITE;
        paddr_s     = PADDR;
        pwdata_s    = PWDATA;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = rsp_err;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    pwrite_s  = cmd_write;
                    paddr_s   = cmd_addr;
                    pwdata_s  = cmd_wdata;
                end else begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                end
            end
            SETUP: begin
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ACCESS: begin
                if (complete_s) begin
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = PWRITE ? '0 : PRDATA;
                    rsp_err_s   = PSLVERR;
                end else if (timeout_s) begin
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = '0;
                    rsp_err_s   = 1'b1;
                end else begin
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                end
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // Output registers, all cleared by reset so an aborted transfer leaves no response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            PSELx     <= psel_s;
            PENABLE   <= penable_s;
            PWRITE    <= pwrite_s;
            PADDR     <= paddr_s;
            PWDATA    <= pwdata_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_err   <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master -- directed, table-driven bench for apb_master with a 256-byte
// APB slave model (addresses >= 256 answer with PSLVERR). Optional timeout
// sequence is built only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total;
    int bad;

    apb_master dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- slave model ----------------
    logic [7:0] mem [256];
    int         waits_cfg;
    int         acc_cnt;
    logic       in_range;

    assign in_range = (PADDR < 32'd256);
    assign PREADY   = (acc_cnt >= waits_cfg);
    assign PRDATA   = in_range ? mem[PADDR[7:0]] : 8'h00;
    assign PSLVERR  = PSELx && PENABLE && !in_range;

    // Count ACCESS cycles elapsed in the current transfer to insert wait states.
    always @(posedge PCLK) begin
        if (PSELx && PENABLE) acc_cnt <= acc_cnt + 1;
        else                  acc_cnt <= 0;
    end

    // Commit completed in-range writes.
    always @(posedge PCLK) begin
        if (PSELx && PENABLE && PREADY && PWRITE && in_range)
            mem[PADDR[7:0]] <= PWDATA;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transfer; returns response data/err, accept-to-response latency in
    // edges (accept edge counted as 1) and number of ACCESS cycles observed.
    // noise=1 keeps cmd_valid high with a different command while busy.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [7:0] d,
                          input int waits, input logic noise,
                          output logic [7:0] rd, output logic er,
                          output int lat, output int acc);
        logic got;
        @(negedge PCLK);
        waits_cfg = waits;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("ready_idle", cmd_ready, 1'b1);
        @(posedge PCLK);
        #1;
        lat = 1;
        acc = 0;
        got = 1'b0;
        cmd_valid = noise;
        cmd_addr  = 32'h77;
        cmd_write = ~w;
        cmd_wdata = 8'hC3;
        check("setup_ctl", {PSELx, PENABLE, PWRITE}, {1'b1, 1'b0, w});
        check("setup_addr", PADDR, a);
        if (w) check("setup_wdata", PWDATA, d);
        for (int i = 0; i < 64; i++) begin
            check("busy_not_ready", cmd_ready, 1'b0);
            if (PSELx && PENABLE) begin
                acc++;
                check("access_hold", {PADDR, PWRITE, PWDATA}, {a, w, (w ? d : PWDATA)});
            end
            @(posedge PCLK);
            #1;
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("rsp_seen", got, 1'b1);
        rd = rsp_rdata;
        er = rsp_err;
        check("post_idle", {PSELx, PENABLE}, 2'b00);
        check("post_hold_addr", PADDR, a);
        @(posedge PCLK);
        #1;
        check("rsp_one_cycle", rsp_valid, 1'b0);
        check("gap_idle", {PSELx, cmd_ready}, 2'b01);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [7:0]  d;
        int          waits;
        logic        noise;
        logic [7:0]  erd;
        logic        eer;
        int          elat;
        int          eacc;
    } vec_t;

    vec_t vecs[10];

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         acc;
    logic       stray;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        waits_cfg = 0;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 8'h0;

        //          w     addr     data   wt nz   erd    eer  lat acc
        vecs[0] = '{1'b1, 32'h0A,  8'hAA, 0, 1'b0, 8'h00, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 32'h0A,  8'h00, 0, 1'b0, 8'hAA, 1'b0, 3, 1};
        vecs[2] = '{1'b1, 32'h0B,  8'h55, 0, 1'b0, 8'h00, 1'b0, 3, 1};
        vecs[3] = '{1'b0, 32'h0B,  8'h00, 0, 1'b0, 8'h55, 1'b0, 3, 1};
        vecs[4] = '{1'b0, 32'h0A,  8'h00, 2, 1'b0, 8'hAA, 1'b0, 5, 3};
        vecs[5] = '{1'b0, 32'd261, 8'h00, 0, 1'b0, 8'h00, 1'b1, 3, 1};
        vecs[6] = '{1'b1, 32'd261, 8'h12, 1, 1'b0, 8'h00, 1'b1, 4, 2};
        vecs[7] = '{1'b1, 32'hFF,  8'h3C, 1, 1'b1, 8'h00, 1'b0, 4, 2};
        vecs[8] = '{1'b0, 32'hFF,  8'h00, 0, 1'b1, 8'h3C, 1'b0, 3, 1};
        vecs[9] = '{1'b1, 32'h0A,  8'h11, 0, 1'b0, 8'h00, 1'b0, 3, 1};

        // reset state
        #12;
        check("reset_ctl", {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, 6'b000001);
        check("reset_data", {PADDR, PWDATA, rsp_rdata}, 48'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // table-driven transfers
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].waits, vecs[i].noise,
                   rd, er, lat, acc);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].erd);
            check($sformatf("v%0d_err", i), er, vecs[i].eer);
            check($sformatf("v%0d_lat", i), lat, vecs[i].elat);
            check($sformatf("v%0d_acc", i), acc, vecs[i].eacc);
        end
        check("mem_0a_after_write", mem[8'h0A], 8'h11);

        // reset in the middle of ACCESS aborts the transfer
        @(negedge PCLK);
        waits_cfg = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0A;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        @(posedge PCLK);
        #1;
        check("abort_in_access", {PSELx, PENABLE}, 2'b11);
        #2;
        PRESETn = 1'b0;
        #1;
        check("abort_ctl", {PSELx, PENABLE, rsp_valid, PWRITE}, 4'b0000);
        check("abort_addr", PADDR, 32'h0);
        stray = 1'b0;
        repeat (2) begin
            @(posedge PCLK);
            #1;
            stray = stray | rsp_valid;
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) begin
            @(posedge PCLK);
            #1;
            stray = stray | rsp_valid | PSELx;
        end
        check("abort_no_rsp", stray, 1'b0);
        do_txn(1'b1, 32'h20, 8'h99, 0, 1'b0, rd, er, lat, acc);
        check("post_reset_wr", {rd, er, lat[7:0]}, {8'h00, 1'b0, 8'd3});
        do_txn(1'b0, 32'h20, 8'h00, 0, 1'b0, rd, er, lat, acc);
        check("post_reset_rd", {rd, er, lat[7:0]}, {8'h99, 1'b0, 8'd3});

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY held low: 16 ACCESS cycles then a forced error response
        do_txn(1'b0, 32'h20, 8'h00, 1000, 1'b0, rd, er, lat, acc);
        check("tmo_rdata", rd, 8'h00);
        check("tmo_err", er, 1'b1);
        check("tmo_acc", acc, 16);
        check("tmo_lat", lat, 18);
        waits_cfg = 0;
        do_txn(1'b0, 32'h20, 8'h00, 0, 1'b0, rd, er, lat, acc);
        check("tmo_after", {rd, er}, {8'h99, 1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the PADDR and cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the PWDATA, PRDATA, cmd_wdata and rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the wait-state limit used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named PCLK and PRESETn.
REQ-005 PCLK  in  1  rising-edge clock for all state.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request from the local requester.
REQ-008 cmd_ready  out  1  master can accept a command.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data, ignored for reads.
REQ-012 rsp_valid  out  1  one-cycle pulse when a transfer completes.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes.
REQ-014 rsp_err  out  1  PSLVERR, or timeout, of the completed transfer; valid with rsp_valid.
REQ-015 PSELx, PENABLE, PWRITE  out  1 each  APB3 control to the slave.
REQ-016 PADDR  out  ADDR_WIDTH  and PWDATA  out  DATA_WIDTH  APB address and write data.
REQ-017 PRDATA  in  DATA_WIDTH, PREADY  in  1, PSLVERR  in  1  APB slave response.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP and ACCESS; all outputs are registered except cmd_ready.
REQ-019 cmd_ready SHALL equal (state == IDLE); a command is accepted on a rising edge with cmd_valid and cmd_ready both high.
REQ-020 Accept: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA; state IDLE->SETUP; PSELx=1, PENABLE=0 in the following cycle.
REQ-021 SETUP SHALL last exactly one cycle; SETUP->ACCESS with PENABLE=1.
REQ-022 In ACCESS with PREADY=0: remain in ACCESS, with PSELx, PENABLE, PADDR, PWRITE and PWDATA held stable.
REQ-023 In ACCESS with PREADY=1, the master SHALL on that edge:
  - capture PRDATA (reads) or 0 (writes) into rsp_rdata;
  - capture PSLVERR into rsp_err;
  - pulse rsp_valid for one cycle;
  - drive PSELx=0 and PENABLE=0;
  - go to IDLE.
REQ-024 Minimum latency from accept to rsp_valid SHALL be 3 cycles with zero wait states, plus 1 cycle per PREADY-low cycle.
REQ-025 Back-to-back commands SHALL have at least one IDLE cycle (PSELx=0) between transfers.
REQ-026 cmd_valid during SETUP or ACCESS SHALL be ignored, not queued.
REQ-027 PADDR, PWDATA and PWRITE SHALL hold their last values in IDLE.
REQ-028 PSLVERR SHALL be sampled only when PSELx, PENABLE and PREADY are all 1.
REQ-029 rsp_valid SHALL have no backpressure; the requester must sample it in its pulse cycle.

Reset
REQ-030 PRESETn low SHALL immediately force: state IDLE; PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err all 0; timeout counter 0.
REQ-031 Reset mid-transfer SHALL abort without producing rsp_valid; the first command after release is accepted normally.

Configuration
REQ-032 When macro APB_MASTER_TIMEOUT_EN is defined:
  - a counter SHALL count consecutive PREADY-low ACCESS cycles;
  - when the counter reaches TIMEOUT_CYCLES, the master SHALL end the transfer as in REQ-023, but with rsp_err=1 and rsp_rdata=0;
  - the counter clears on leaving ACCESS.
REQ-033 When APB_MASTER_TIMEOUT_EN is undefined, no counter SHALL exist and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-034 Write 0x0A=0xAA with slave PREADY=1 -> SETUP 1 cycle, ACCESS 1 cycle, PWDATA=0xAA stable, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-035 Read 0x0A after that write -> rsp_rdata=0xAA, rsp_err=0; read of 0x0B after writing 0x55 -> rsp_rdata=0x55.
REQ-036 Read with 2 PREADY-low cycles -> PADDR and controls stable for 3 ACCESS cycles; rsp_valid 5 cycles after accept.
REQ-037 Read address 261 (out of range, slave asserts PSLVERR) -> rsp_err=1 on rsp_valid.
REQ-038 PRESETn low during ACCESS -> PSELx, PENABLE and rsp_valid 0 immediately, no response; the next write after release completes normally.
REQ-039 With APB_MASTER_TIMEOUT_EN and PREADY held 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, PSELx=0.
